// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the row-serial multiplier.
// No timing or flow control of its own.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 8;

  // Bits needed to count multiplier bit positions 0..width-1.
  function automatic int CNT_W(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_row.sv
// One row of carry-save bitmult cells: {cout, sum} = p + (ybit ? x : 0).
// Purely combinational, zero latency, no backpressure.
module bitmult (
  input  logic xin,
  input  logic yin,
  input  logic pin,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic pp;

  assign pp   = xin & yin;
  assign sum  = pp ^ pin ^ cin;
  assign cout = (pp & pin) | (pp & cin) | (pin & cin);

endmodule

module mult_row import mult_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] x,
  input  logic             ybit,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bitmult u_cell (
      .xin  (x[i]),
      .yin  (ybit),
      .pin  (p[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_array_mult.sv
// Row-serial unsigned multiplier, one multiplier bit per cycle through a single cell row.
// Done pulses WIDTH+1 cycles after an accepted start; start is ignored while busy.
module seq_array_mult import mult_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = CNT_W(WIDTH);

  mult_state_t state, state_nxt;

  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] row_sum;
  logic             row_cout;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  // acc_hi is acc[WIDTH:1]; acc[0] is retired into lo the same cycle it is formed.
  mult_row #(.WIDTH(WIDTH)) u_row (
    .x    (x_r),
    .ybit (y_r[cnt]),
    .p    (acc_hi),
    .sum  (row_sum),
    .cout (row_cout)
  );

  always_comb begin
    lo_nxt      = lo;
    lo_nxt[cnt] = row_sum[0];
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      acc_hi  <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            x_r    <= x;
            y_r    <= y;
            acc_hi <= '0;
            lo     <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc_hi <= {row_cout, row_sum[WIDTH-1:1]};
          lo     <= lo_nxt;
          cnt    <= cnt + CW'(1);
          // Load the product on the last row so it is already valid while done is high.
          if (last) product <= {row_cout, row_sum[WIDTH-1:1], lo_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_mult.sv
// Self-checking bench: countdown reference model for the 8-bit instance, directed and random ops on 8- and 4-bit instances.
module tb_seq_array_mult;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start8 = 1'b0;
  logic [7:0]   x8 = '0;
  logic [7:0]   y8 = '0;
  logic         busy8;
  logic         done8;
  logic [15:0]  product8;

  logic         rst4_n = 1'b0;
  logic         start4 = 1'b0;
  logic [3:0]   x4 = '0;
  logic [3:0]   y4 = '0;
  logic         busy4;
  logic         done4;
  logic [7:0]   product4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_array_mult #(.WIDTH(W8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .x       (x8),
    .y       (y8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  seq_array_mult #(.WIDTH(W4)) dut4 (
    .clk     (clk),
    .rst_n   (rst4_n),
    .start   (start4),
    .x       (x4),
    .y       (y4),
    .busy    (busy4),
    .done    (done4),
    .product (product4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for dut8: an accepted start opens a window of W8+1 busy cycles,
  // the last of which carries done and the new product.
  int          m_rem = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_prod = '0;
  bit          mon_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_pend = '0;
      m_prod = '0;
    end else if (m_rem == 0) begin
      if (start8 === 1'b1) begin
        m_rem  = W8 + 1;
        m_pend = 16'(x8) * 16'(y8);
      end
    end else begin
      m_rem--;
      if (m_rem == 1) m_prod = m_pend;
    end
    mon_en = 1'b1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_busy", 32'(busy8), 32'(m_rem > 0));
      chk("mon_done", 32'(done8), 32'(m_rem == 1));
      chk("mon_product", 32'(product8), 32'(m_prod));
    end
  end

  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    start8 = 1'b1;
    x8 = a;
    y8 = b;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    x8 = ~a;
    y8 = ~b;
  endtask

  // Waits for done after a launch; returns cycles counted from the accepting edge.
  task automatic wait_done8(output int n, output int bc);
    bit got;
    n = 0;
    bc = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (busy8 === 1'b1) bc++;
      if (done8 === 1'b1) got = 1'b1;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string nm);
    int n;
    int bc;
    launch8(a, b);
    wait_done8(n, bc);
    chk({nm, "_latency"}, 32'(n), 32'(W8 + 1));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(W8 + 1));
    chk({nm, "_product"}, 32'(product8), 32'(exp));
    chk({nm, "_model"}, 32'(m_prod), 32'(exp));
  endtask

  task automatic run8();
    int n;
    int bc;
    int dcount;
    logic [7:0] a;
    logic [7:0] b;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_product", 32'(product8), 32'd0);
    rst_n = 1'b1;

    op8(8'd13, 8'd11, 16'd143, "basic");
    op8(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
    op8(8'h00, 8'hA5, 16'h0000, "zero_x");
    op8(8'h01, 8'h80, 16'h0080, "one_msb");

    // Start pulsed during RUN must be ignored.
    launch8(8'd3, 8'd5);
    repeat (3) @(negedge clk);
    start8 = 1'b1;
    x8 = 8'd7;
    y8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(n, bc);
    chk("busy_start_product", 32'(product8), 32'd15);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) dcount++;
    end
    chk("busy_start_no_second_done", 32'(dcount), 32'd0);
    chk("busy_start_hold", 32'(product8), 32'd15);

    // Back-to-back: relaunch in the IDLE cycle right after done.
    op8(8'd10, 8'd10, 16'd100, "b2b_first");
    op8(8'd200, 8'd100, 16'd20000, "b2b_second");

    // Reset during RUN cycle 4 discards the operation.
    launch8(8'd50, 8'd3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_product", 32'(product8), 32'd0);
    op8(8'd9, 8'd9, 16'd81, "after_reset");

    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      op8(a, b, 16'(a) * 16'(b), "rand8");
    end
  endtask

  task automatic run4();
    int n;
    bit got;
    logic [3:0] a;
    logic [3:0] b;

    rst4_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("w4_reset_product", 32'(product4), 32'd0);
    rst4_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      start4 = 1'b1;
      x4 = a;
      y4 = b;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (done4 === 1'b1) got = 1'b1;
      end
      chk("w4_latency", 32'(n), 32'(W4 + 1));
      chk("w4_product", 32'(product4), 32'(8'(a) * 8'(b)));
      @(negedge clk);
      chk("w4_done_width", 32'(done4), 32'd0);
    end
  endtask

  initial begin
    fork
      run8();
      run4();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
